// File: rtl/ovf_pkg.sv
// Shared types and defaults for the overflow exception controller.
// Used by overflow_exception_ctrl and ovf_log_ram.
package ovf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PENDING  = 2'd1,
      ST_COOLDOWN = 2'd2
   } ovf_state_e;

   localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
   localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

   localparam int unsigned DEF_COOLDOWN = 4;
   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_DROP_W   = 8;
   localparam int unsigned LOG_DEPTH    = 4;

endpackage : ovf_pkg

// File: rtl/ovf_log_ram.sv
// Four-entry ring of the most recently raised fault addresses.
// Instantiated by overflow_exception_ctrl only when OVF_LOG_EN is defined.
module ovf_log_ram
   import ovf_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rst_us,
   input  logic        wr_en_i,
   input  logic [31:0] wr_data_i,
   input  logic [1:0]  rd_idx_i,
   output logic [31:0] rd_data_o,
   output logic [2:0]  cnt_o
);

   logic [31:0] mem_q [LOG_DEPTH];
   logic [31:0] mem_d [LOG_DEPTH];
   logic [1:0]  wptr_q, wptr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  rd_ptr;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (wr_en_i) begin
         mem_d[wptr_q] = wr_data_i;
         wptr_d        = wptr_q + 2'd1;
         if (cnt_q != 3'(LOG_DEPTH)) cnt_d = cnt_q + 3'd1;
      end
   end

   // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
   assign rd_ptr    = 2'(wptr_q - 2'd1 - rd_idx_i);
   assign rd_data_o = mem_q[rd_ptr];
   assign cnt_o     = cnt_q;

   always_ff @(posedge clk_i) begin
      // NOTE: the entries are reset on purpose so that a cleared log reads back zeros;
      // a plain storage array would normally be left without reset.
      if (!rst_ni || rst_us) begin
         for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule : ovf_log_ram

// File: rtl/overflow_exception_ctrl.sv
// Converts qualified base-address-buffer overflows into a registered access-fault request
// with valid/ack handshake, post-ack cooldown and saturating stats. Optional log: OVF_LOG_EN.
module overflow_exception_ctrl
   import ovf_pkg::*;
#(
   parameter int unsigned COOLDOWN = DEF_COOLDOWN,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned DROP_W   = DEF_DROP_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rst_us,
   input  logic              en_i,
   input  logic              mem_valid_i,
   input  logic              mem_is_store_i,
   input  logic [31:0]       mem_addr_i,
   input  logic              read_overflow_i,
   output logic              ex_valid_o,
   output logic [3:0]        ex_cause_o,
   output logic [31:0]       ex_tval_o,
   input  logic              ex_ack_i,
   output logic              busy_o,
   output logic [CNT_W-1:0]  overflow_cnt_o,
   output logic [DROP_W-1:0] drop_cnt_o
`ifdef OVF_LOG_EN
  ,input  logic [1:0]        log_idx_i,
   output logic [31:0]       log_addr_o,
   output logic [2:0]        log_cnt_o
`endif
);

   localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   ovf_state_e        state_q, state_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic              valid_q, valid_d;
   logic [3:0]        cause_q, cause_d;
   logic [31:0]       tval_q, tval_d;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              qov;

   assign qov = en_i & mem_valid_i & read_overflow_i;

   always_comb begin
      state_d    = state_q;
      cd_d       = cd_q;
      valid_d    = valid_q;
      cause_d    = cause_q;
      tval_d     = tval_q;
      ovf_cnt_d  = ovf_cnt_q;
      drop_cnt_d = drop_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (qov) begin
               state_d = ST_PENDING;
               valid_d = 1'b1;
               tval_d  = mem_addr_i;
               cause_d = mem_is_store_i ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end
         end
         ST_PENDING: begin
            if (ex_ack_i) begin
               state_d = ST_COOLDOWN;
               valid_d = 1'b0;
               cd_d    = CD_W'(COOLDOWN - 1);
            end
         end
         ST_COOLDOWN: begin
            // Counting down through zero gives exactly COOLDOWN cycles in this state.
            if (cd_q == '0) state_d = ST_IDLE;
            else            cd_d    = cd_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (qov && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
      if (qov && state_q != ST_IDLE && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values computed by the always_comb above.
      if (!rst_ni || rst_us) begin
         state_q    <= ST_IDLE;
         cd_q       <= '0;
         valid_q    <= 1'b0;
         cause_q    <= '0;
         tval_q     <= '0;
         ovf_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cd_q       <= cd_d;
         valid_q    <= valid_d;
         cause_q    <= cause_d;
         tval_q     <= tval_d;
         ovf_cnt_q  <= ovf_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ex_valid_o     = valid_q;
   assign ex_cause_o     = cause_q;
   assign ex_tval_o      = tval_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign overflow_cnt_o = ovf_cnt_q;
   assign drop_cnt_o     = drop_cnt_q;

`ifdef OVF_LOG_EN
   ovf_log_ram u_log (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rst_us    (rst_us),
      .wr_en_i   ((state_q == ST_IDLE) && qov),
      .wr_data_i (mem_addr_i),
      .rd_idx_i  (log_idx_i),
      .rd_data_o (log_addr_o),
      .cnt_o     (log_cnt_o)
   );
`endif

endmodule : overflow_exception_ctrl

// File: tb/tb_overflow_exception_ctrl.sv
// Directed scoreboard bench for overflow_exception_ctrl (default COOLDOWN=4, CNT_W=16, DROP_W=8).
// The log section is compiled only when OVF_LOG_EN is defined.
module tb_overflow_exception_ctrl;

   typedef struct packed {
      logic [3:0]  cause;
      logic [31:0] tval;
   } req_t;

   logic        clk_i = 1'b0;
   logic        rst_ni, rst_us, en_i, mem_valid_i, mem_is_store_i, read_overflow_i, ex_ack_i;
   logic [31:0] mem_addr_i;
   logic        ex_valid_o, busy_o;
   logic [3:0]  ex_cause_o;
   logic [31:0] ex_tval_o;
   logic [15:0] overflow_cnt_o;
   logic [7:0]  drop_cnt_o;
`ifdef OVF_LOG_EN
   logic [1:0]  log_idx_i;
   logic [31:0] log_addr_o;
   logic [2:0]  log_cnt_o;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   req_t exp_q[$];
   logic [15:0] exp_ovf;
   logic [7:0]  exp_drop;

   always #5 clk_i = ~clk_i;

   overflow_exception_ctrl dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .rst_us          (rst_us),
      .en_i            (en_i),
      .mem_valid_i     (mem_valid_i),
      .mem_is_store_i  (mem_is_store_i),
      .mem_addr_i      (mem_addr_i),
      .read_overflow_i (read_overflow_i),
      .ex_valid_o      (ex_valid_o),
      .ex_cause_o      (ex_cause_o),
      .ex_tval_o       (ex_tval_o),
      .ex_ack_i        (ex_ack_i),
      .busy_o          (busy_o),
      .overflow_cnt_o  (overflow_cnt_o),
      .drop_cnt_o      (drop_cnt_o)
`ifdef OVF_LOG_EN
     ,.log_idx_i       (log_idx_i),
      .log_addr_o      (log_addr_o),
      .log_cnt_o       (log_cnt_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pops the oldest expected request and compares it with what the DUT presents.
   task automatic check_req(input string tag);
      req_t e;
      check({tag, "_valid"}, {31'd0, ex_valid_o}, 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_cause"}, {28'd0, ex_cause_o}, {28'd0, e.cause});
         check({tag, "_tval"}, ex_tval_o, e.tval);
      end
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_ovf"}, {16'd0, overflow_cnt_o}, {16'd0, exp_ovf});
      check({tag, "_drop"}, {24'd0, drop_cnt_o}, {24'd0, exp_drop});
   endtask

   task automatic clear_model();
      exp_ovf  = '0;
      exp_drop = '0;
      exp_q.delete();
   endtask

   // Presents one qualified overflow for a single edge; 'raise' says whether the
   // bench expects it to become a request (controller idle) or to be dropped.
   task automatic apply_qov(input logic store, input logic [31:0] addr, input logic raise);
      en_i            = 1'b1;
      mem_valid_i     = 1'b1;
      read_overflow_i = 1'b1;
      mem_is_store_i  = store;
      mem_addr_i      = addr;
      if (exp_ovf != 16'hFFFF) exp_ovf++;
      if (raise) exp_q.push_back('{cause: store ? 4'd7 : 4'd5, tval: addr});
      else if (exp_drop != 8'hFF) exp_drop++;
      tick();
      mem_valid_i     = 1'b0;
      read_overflow_i = 1'b0;
      mem_is_store_i  = 1'b0;
      mem_addr_i      = '0;
   endtask

   task automatic ack_once();
      ex_ack_i = 1'b1;
      tick();
      ex_ack_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_o && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int busy_cycles;
      rst_ni = 1'b0; rst_us = 1'b0; en_i = 1'b1; mem_valid_i = 1'b0; mem_is_store_i = 1'b0;
      read_overflow_i = 1'b0; ex_ack_i = 1'b0; mem_addr_i = '0;
`ifdef OVF_LOG_EN
      log_idx_i = '0;
`endif
      clear_model();
      tick();
      tick();
      rst_ni = 1'b1;
      check("rst_valid", {31'd0, ex_valid_o}, 32'd0);
      check("rst_cause", {28'd0, ex_cause_o}, 32'd0);
      check("rst_tval", ex_tval_o, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check_cnts("rst");

      // Load fault, held three cycles, then ack and measure the cooldown length.
      apply_qov(1'b0, 32'h8000_1004, 1'b1);
      check_req("ld");
      check_cnts("ld");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ld_hold_valid", {31'd0, ex_valid_o}, 32'd1);
         check("ld_hold_tval", ex_tval_o, 32'h8000_1004);
      end
      ack_once();
      check("ld_ack_valid", {31'd0, ex_valid_o}, 32'd0);
      busy_cycles = 0;
      while (busy_o && busy_cycles < 20) begin
         busy_cycles++;
         tick();
      end
      check("cooldown_len", 32'(busy_cycles), 32'd4);

      // Store fault followed by two overflows that must be dropped.
      apply_qov(1'b1, 32'h8000_2000, 1'b1);
      apply_qov(1'b0, 32'h8000_3000, 1'b0);
      apply_qov(1'b1, 32'h8000_4000, 1'b0);
      check_req("st");
      check_cnts("st");

      // Overflow coincident with ack is dropped; first idle cycle raises again.
      ex_ack_i = 1'b1;
      apply_qov(1'b0, 32'h8000_5000, 1'b0);
      ex_ack_i = 1'b0;
      check("ackdrop_valid", {31'd0, ex_valid_o}, 32'd0);
      check("ackdrop_busy", {31'd0, busy_o}, 32'd1);
      check_cnts("ackdrop");
      wait_idle("cd1");
      apply_qov(1'b0, 32'h8000_6000, 1'b1);
      check_req("post_cd");
      ack_once();
      ack_once();
      check("stray_ack_valid", {31'd0, ex_valid_o}, 32'd0);
      wait_idle("cd2");
      check_cnts("post_cd");

      // Custom clear, then a disabled checker must ignore overflows.
      rst_us = 1'b1;
      tick();
      rst_us = 1'b0;
      clear_model();
      check_cnts("rst_us");
      en_i = 1'b0; mem_valid_i = 1'b1; read_overflow_i = 1'b1; mem_addr_i = 32'h1234_5678;
      for (int i = 0; i < 10; i++) tick();
      mem_valid_i = 1'b0; read_overflow_i = 1'b0;
      check("dis_valid", {31'd0, ex_valid_o}, 32'd0);
      check("dis_busy", {31'd0, busy_o}, 32'd0);
      check_cnts("dis");

      // rst_us while a request is pending discards it.
      apply_qov(1'b1, 32'hA000_0000, 1'b1);
      check_req("pre_clr");
      rst_us = 1'b1;
      tick();
      rst_us = 1'b0;
      clear_model();
      check("clr_valid", {31'd0, ex_valid_o}, 32'd0);
      check("clr_cause", {28'd0, ex_cause_o}, 32'd0);
      check("clr_tval", ex_tval_o, 32'd0);
      check("clr_busy", {31'd0, busy_o}, 32'd0);
      check_cnts("clr");

      // 300 overflows against a never-acked request saturate the drop counter.
      apply_qov(1'b0, 32'h0000_1000, 1'b1);
      for (int i = 1; i <= 300; i++) apply_qov(1'b0, 32'h0000_1000 + 32'(4 * i), 1'b0);
      check_req("sat");
      check_cnts("sat");
      check("sat_ovf_abs", {16'd0, overflow_cnt_o}, 32'd301);
      check("sat_drop_abs", {24'd0, drop_cnt_o}, 32'hFF);

      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      clear_model();
      check("rst2_valid", {31'd0, ex_valid_o}, 32'd0);

`ifdef OVF_LOG_EN
      check("log_rst_cnt", {29'd0, log_cnt_o}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         apply_qov(1'b0, 32'(16 * i), 1'b1);
         check_req("log_raise");
         ack_once();
         apply_qov(1'b0, 32'hDEAD_0000, 1'b0);
         wait_idle("log_cd");
      end
      check("log_cnt", {29'd0, log_cnt_o}, 32'd4);
      log_idx_i = 2'd0; #1;
      check("log_idx0", log_addr_o, 32'h50);
      log_idx_i = 2'd1; #1;
      check("log_idx1", log_addr_o, 32'h40);
      log_idx_i = 2'd3; #1;
      check("log_idx3", log_addr_o, 32'h20);
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_overflow_exception_ctrl
